// File: rtl/i2s_playback_engine.sv
// I2S / left-justified / TDM playback serialiser slaved to CODEC bclk/pblrc, with frame FIFO.
// Optional feature: define I2S_PLAYBACK_UNDERRUN_CNT_EN for the saturating 16-bit underrun counter.
module i2s_playback_engine #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned MODE         = 0
) (
  input  logic                                  board_clk,
  input  logic                                  reset,
  input  logic                                  output_en,
  input  logic                                  s_frame_valid,
  output logic                                  s_frame_ready,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]  s_frame_data,
  input  logic                                  ac_bclk,
  input  logic                                  ac_pblrc,
  output logic                                  ac_pbdat,
  output logic                                  ac_muten,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
  output logic                                  underrun,
  input  logic                                  clear_underrun,
  output logic [15:0]                           underrun_count
);

  localparam int unsigned FRAME_W = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned HALF_W  = FRAME_W / 2;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned CW      = $clog2(HALF_W + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_W + 1);

  logic bclk_s1, bclk_s2, bclk_d;
  logic lrc_s1, lrc_s2, lrc_d;
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [FRAME_W-1:0] frame_buf;
  logic [HALF_W-1:0]  sh;
  logic [CW-1:0]      cnt;
  logic               playing;

  logic               fe, bnd, fall_bnd, empty, full, push, pop, urun_evt;
  logic [FRAME_W-1:0] frame_next, src;
  logic [HALF_W-1:0]  half_src, payload, sh_next;
  logic [CW-1:0]      cnt_next;
  logic               bit_next, in_win, playing_next;

  // Edge and half-boundary detection on the synchronised CODEC clocks
  always_comb begin
    fe           = bclk_d & ~bclk_s2;
    bnd          = fe & (lrc_s2 != lrc_d);
    fall_bnd     = bnd & ~lrc_s2;
    empty        = (fifo_level == '0);
    full         = (fifo_level == LW'(FIFO_DEPTH));
    push         = s_frame_valid & ~full;
    pop          = fall_bnd & output_en & ~empty;
    urun_evt     = fall_bnd & output_en & empty;
    frame_next   = pop ? mem[rd_ptr] : '0;
    src          = fall_bnd ? frame_next : frame_buf;
    half_src     = lrc_s2 ? src[FRAME_W-1:HALF_W] : src[HALF_W-1:0];
    playing_next = output_en & (fall_bnd | playing);
  end

  // Lowest channel of the half goes out first, so it lands in the payload MSBs
  for (genvar c = 0; c < NUM_CHANNELS / 2; c++) begin : g_slot
    assign payload[HALF_W-1-c*SAMPLE_WIDTH -: SAMPLE_WIDTH] =
      half_src[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  // Bit sequencing: boundary reloads the shifter, other falling edges shift
  always_comb begin
    cnt_next = cnt;
    sh_next  = sh;
    bit_next = 1'b0;
    if (fe) begin
      if (bnd) begin
        cnt_next = '0;
        if (MODE == 0) begin
          sh_next = payload;
        end else begin
          bit_next = payload[HALF_W-1];
          sh_next  = payload << 1;
        end
      end else begin
        if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
        bit_next = sh[HALF_W-1];
        sh_next  = sh << 1;
      end
    end
    if (MODE == 0) in_win = (cnt_next != '0) && (cnt_next <= CW'(HALF_W));
    else           in_win = (cnt_next < CW'(HALF_W));
  end

  assign s_frame_ready = ~full;

  always_ff @(posedge board_clk) begin
    if (reset) begin
      {bclk_s1, bclk_s2, bclk_d} <= '0;
      {lrc_s1, lrc_s2, lrc_d}    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      frame_buf  <= '0;
      sh         <= '0;
      cnt        <= '0;
      playing    <= 1'b0;
      ac_pbdat   <= 1'b0;
      ac_muten   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      bclk_s1  <= ac_bclk;
      bclk_s2  <= bclk_s1;
      bclk_d   <= bclk_s2;
      lrc_s1   <= ac_pblrc;
      lrc_s2   <= lrc_s1;
      if (fe) lrc_d <= lrc_s2;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (fall_bnd) frame_buf <= frame_next;
      sh       <= sh_next;
      cnt      <= cnt_next;
      playing  <= playing_next;
      ac_muten <= output_en;
      if (!output_en) ac_pbdat <= 1'b0;
      else if (fe)    ac_pbdat <= bit_next & in_win & playing_next;
      // A new underrun wins over a simultaneous clear
      if (urun_evt)            underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end

  always_ff @(posedge board_clk) begin
    if (push) mem[wr_ptr] <= s_frame_data;
  end

`ifdef I2S_PLAYBACK_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt;

  always_ff @(posedge board_clk) begin
    if (reset)                                 urun_cnt <= '0;
    else if (urun_evt && urun_cnt != 16'hFFFF) urun_cnt <= urun_cnt + 16'd1;
  end

  assign underrun_count = urun_cnt;
`else
  assign underrun_count = 16'h0000;
`endif

endmodule
